// File: rtl/data_encrypt_ser.sv
// data_encrypt_ser: word-in, bit-serial-out self-synchronizing scrambler, c[n] = d[n] ^ c[n-3] ^ c[n-5].
// Optional DATA_ENCRYPT_BYPASS_EN adds i_bypass, which sends plaintext for test mode.
module data_encrypt_ser #(
  parameter int unsigned DATA_W   = 8,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
`ifdef DATA_ENCRYPT_BYPASS_EN
  input  logic              i_bypass,
`endif
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_code,
  output logic              o_bit_vld,
  output logic              o_busy
);

  localparam int unsigned   CW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        hist_q, hist_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;
  logic              accept;
  logic              d_bit;
  logic              c_bit;

  // Ready while idle or while the last bit of the current word is on the line
  always_comb begin
    o_ready = (state_q == S_IDLE) ||
              ((state_q == S_SHIFT) && (cnt_q == LAST));
  end

  // Pick the plaintext bit for the next clock and advance word/counter state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    vld_d   = 1'b0;
    busy_d  = 1'b0;
    d_bit   = IDLE_BIT;
    accept  = i_valid && o_ready;
    if (accept) begin
      state_d = S_SHIFT;
      cnt_d   = '0;
      word_d  = i_data;
      d_bit   = i_data[0];
      vld_d   = 1'b1;
      busy_d  = 1'b1;
    end else if ((state_q == S_SHIFT) && (cnt_q != LAST)) begin
      cnt_d   = cnt_q + 1'b1;
      d_bit   = word_q[cnt_d];
      vld_d   = 1'b1;
      busy_d  = 1'b1;
    end else begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Scramble against the code history; history shifts every clock
  always_comb begin
`ifdef DATA_ENCRYPT_BYPASS_EN
    c_bit  = i_bypass ? d_bit : (d_bit ^ hist_q[2] ^ hist_q[0]);
`else
    c_bit  = d_bit ^ hist_q[2] ^ hist_q[0];
`endif
    hist_d = {c_bit, hist_q[4:1]};
  end

  // State, history and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      hist_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  assign o_code    = hist_q[4];
  assign o_bit_vld = vld_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_data_encrypt_ser.sv
// tb_data_encrypt_ser: random and directed stimulus against a bit-queue model
// plus a loopback descrambler on the DUT output.
module tb_data_encrypt_ser;

  localparam int   W        = 8;
  localparam logic IDLE_BIT = 1'b0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] i_data = '0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic         o_code;
  logic         o_bit_vld;
  logic         o_busy;
`ifdef DATA_ENCRYPT_BYPASS_EN
  logic         i_bypass = 1'b0;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  data_encrypt_ser #(
    .DATA_W  (W),
    .IDLE_BIT(IDLE_BIT)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
`ifdef DATA_ENCRYPT_BYPASS_EN
    .i_bypass (i_bypass),
`endif
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_code   (o_code),
    .o_bit_vld(o_bit_vld),
    .o_busy   (o_busy)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a queue of plaintext bits still to send and the
  // full list of code bits emitted since reset.
  logic m_code  = 1'b0;
  logic m_vld   = 1'b0;
  logic m_ready = 1'b1;
  bit   m_pend[$];
  bit   m_hist[$];

  function automatic bit m_past(input int k);
    if (m_hist.size() >= k) return m_hist[m_hist.size() - k];
    return 1'b0;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pend.delete();
      m_hist.delete();
      m_code = 1'b0;
      m_vld  = 1'b0;
    end else begin
      bit d;
      bit c;
      if (i_valid && m_pend.size() == 0) begin
        for (int i = 1; i < W; i++) m_pend.push_back(i_data[i]);
        d     = i_data[0];
        m_vld = 1'b1;
      end else if (m_pend.size() > 0) begin
        d     = m_pend.pop_front();
        m_vld = 1'b1;
      end else begin
        d     = IDLE_BIT;
        m_vld = 1'b0;
      end
      c = d ^ m_past(3) ^ m_past(5);
`ifdef DATA_ENCRYPT_BYPASS_EN
      if (i_bypass) c = d;
`endif
      m_hist.push_back(c);
      m_code = c;
    end
    m_ready = (m_pend.size() == 0);
  end

  // Per-cycle compare plus a descrambler fed from the DUT code stream
  bit lb_on = 1'b0;
  bit dh[$];
  bit rx[$];
  bit sent[$];

  function automatic bit d_past(input int k);
    if (dh.size() >= k) return dh[dh.size() - k];
    return 1'b0;
  endfunction

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      dh.delete();
    end else begin
      bit p;
      chk("code", o_code, m_code);
      chk("bit_vld", o_bit_vld, m_vld);
      chk("busy", o_busy, m_vld);
      chk("ready", o_ready, m_ready);
      p = o_code ^ d_past(3) ^ d_past(5);
      dh.push_back(o_code);
      if (lb_on && o_bit_vld) rx.push_back(p);
    end
  end

  // Called at a negedge; returns at the negedge with bit 0 on the line
  task automatic send(input logic [7:0] w);
    int t;
    t = 0;
    i_data  = w;
    i_valid = 1'b1;
    while (!o_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t >= 64) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_data  = 8'($urandom);
    @(negedge clk);
  endtask

  task automatic capture(output logic [7:0] b, output int nv);
    nv = 0;
    b  = '0;
    for (int i = 0; i < 8; i++) begin
      b[i] = o_code;
      nv += int'(o_bit_vld);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] cap;
    logic [7:0] w;
    logic [7:0] ws [3];
    int         nv;
    int         k;
    int         vhi;
    int         first;
    int         last;
    int         acc_at[$];
    int         mism;

    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_code", o_code, 0);
      chk("idle_vld", o_bit_vld, 0);
      chk("idle_ready", o_ready, 1);
    end

    send(8'h01);
    capture(cap, nv);
    chk("w01_code", cap, 8'h69);
    chk("w01_vld_cnt", nv, 8);
    chk("w01_vld_after", o_bit_vld, 0);

    ws[0] = 8'hA5;
    ws[1] = 8'h3C;
    ws[2] = 8'hFF;
    k = 0;
    vhi = 0;
    first = -1;
    last = -1;
    i_data = ws[0];
    i_valid = 1'b1;
    for (int c = 0; c < 32; c++) begin
      bit acc;
      acc = o_ready && i_valid;
      if (acc) acc_at.push_back(c);
      if (o_bit_vld) begin
        vhi++;
        if (first < 0) first = c;
        last = c;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        k++;
        if (k < 3) i_data = ws[k];
        else i_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_accepts", acc_at.size(), 3);
    chk("b2b_vld_total", vhi, 24);
    chk("b2b_vld_span", last - first + 1, 24);
    if (acc_at.size() == 3) begin
      chk("b2b_gap1", acc_at[1] - acc_at[0], 8);
      chk("b2b_gap2", acc_at[2] - acc_at[1], 8);
    end

    lb_on = 1'b1;
    for (int i = 0; i < 200; i++) begin
      w = 8'($urandom);
      for (int b = 0; b < 8; b++) sent.push_back(w[b]);
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 12)) @(negedge clk);
      send(w);
    end
    repeat (16) @(negedge clk);
    lb_on = 1'b0;
    chk("lb_count", rx.size(), sent.size());
    mism = 0;
    for (int i = 0; i < sent.size() && i < rx.size(); i++)
      if (rx[i] !== sent[i]) mism++;
    chk("lb_bits", mism, 0);

    send(8'h01);
    repeat (3) @(negedge clk);
    chk("mid_vld", o_bit_vld, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_code", o_code, 0);
    chk("rst_vld", o_bit_vld, 0);
    chk("rst_busy", o_busy, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    send(8'h01);
    capture(cap, nv);
    chk("rst_w01_code", cap, 8'h69);
    chk("rst_w01_vld_cnt", nv, 8);

`ifdef DATA_ENCRYPT_BYPASS_EN
    i_bypass = 1'b1;
    @(negedge clk);
    send(8'h5A);
    capture(cap, nv);
    chk("byp_5a", cap, 8'h5A);
    i_bypass = 1'b0;
`endif

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
